// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC vectoring and rotation blocks.
// Angles use a 16-bit binary-angle format: 0x4000 = +pi/2, 0x8000 = -pi.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int ATAN_N  = 15;

    // atan(2^-i) in angle LSBs (pi/32768), i = 0..14
    localparam logic [ANGLE_W-1:0] ATAN_TABLE [ATAN_N] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B,
        16'h0145, 16'h00A2, 16'h0051, 16'h0028, 16'h0014,
        16'h000A, 16'h0005, 16'h0002, 16'h0001, 16'h0000
    };

    // Inverse CORDIC gain, 0.60725 in Q4.12
    localparam logic [15:0] K_FACTOR = 16'h09B7;

    localparam logic [ANGLE_W-1:0] HALF_PI     = 16'h4000;
    localparam logic [ANGLE_W-1:0] NEG_HALF_PI = 16'hC000;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SCALE,
        DONE
    } cordic_state_t;

endpackage

// File: rtl/cordic_k_scale.sv
// Gain compensation: multiply by K, drop FRAC bits, saturate high and
// clamp negative residue to zero. Purely combinational.
module cordic_k_scale #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int GUARD = 2
) (
    input  logic signed [WIDTH+GUARD-1:0] x,
    output logic        [WIDTH-1:0]       mag
);
    import cordic_pkg::*;

    localparam int XW = WIDTH + GUARD;
    localparam int PW = XW + WIDTH;

    logic signed [PW-1:0] x_wide;
    logic signed [PW-1:0] k_wide;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] shifted;

    // Full-precision product, then saturate to the positive WIDTH-bit range
    always_comb begin
        x_wide  = {{WIDTH{x[XW-1]}}, x};
        k_wide  = {{(PW-16){1'b0}}, K_FACTOR};
        product = x_wide * k_wide;
        shifted = product >>> FRAC;
        if (shifted[PW-1]) begin
            mag = '0;
        end else if (|shifted[PW-2:WIDTH-1]) begin
            mag = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            mag = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: (x, y) -> magnitude and atan2(y, x).
// One micro-rotation per clock; result appears 16 edges after acceptance
// and is held until the consumer takes it.
module cordic_vec #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int ITER  = 15,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mag_out,
    output logic [WIDTH-1:0] angle_out
);
    // Imported after the parameter list so the ITER parameter keeps its
    // name; the ITER state is therefore always written cordic_pkg::ITER.
    import cordic_pkg::*;

    localparam int XW = WIDTH + GUARD;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    cordic_state_t state;
    cordic_state_t state_next;

    logic signed [XW-1:0]    x_reg;
    logic signed [XW-1:0]    y_reg;
    logic        [WIDTH-1:0] z_reg;
    logic        [CW-1:0]    iter_cnt;
    logic                    zero_flag;

    logic signed [XW-1:0]    x_ext;
    logic signed [XW-1:0]    y_ext;
    logic signed [XW-1:0]    x_shift;
    logic signed [XW-1:0]    y_shift;
    logic        [WIDTH-1:0] atan_step;
    logic        [WIDTH-1:0] scaled_mag;
    logic                    accept;
    logic                    last_iter;

    assign x_ext     = {{GUARD{x_in[WIDTH-1]}}, x_in};
    assign y_ext     = {{GUARD{y_in[WIDTH-1]}}, y_in};
    assign x_shift   = x_reg >>> iter_cnt;
    assign y_shift   = y_reg >>> iter_cnt;
    assign atan_step = WIDTH'(ATAN_TABLE[iter_cnt]);
    assign accept    = in_valid & in_ready;
    assign last_iter = (iter_cnt == CW'(ITER - 1));

    cordic_k_scale #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .GUARD (GUARD)
    ) u_k_scale (
        .x   (x_reg),
        .mag (scaled_mag)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a result in DONE can be consumed and replaced on one edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE:             if (accept) state_next = cordic_pkg::ITER;
            cordic_pkg::ITER: if (last_iter) state_next = SCALE;
            SCALE:            state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? cordic_pkg::ITER : IDLE;
                end
            end
            default:          state_next = IDLE;
        endcase
    end

    // Handshake outputs; in_ready depends on out_ready but never on in_valid
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Datapath: quadrant fold on accept, micro-rotations, then gain/output
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_cnt  <= '0;
            zero_flag <= 1'b0;
            mag_out   <= '0;
            angle_out <= '0;
        end else if (accept) begin
            iter_cnt  <= '0;
            zero_flag <= (x_in == '0) && (y_in == '0);
            if (!x_in[WIDTH-1]) begin
                x_reg <= x_ext;
                y_reg <= y_ext;
                z_reg <= '0;
            end else if (!y_in[WIDTH-1]) begin
                x_reg <= y_ext;
                y_reg <= -x_ext;
                z_reg <= WIDTH'(HALF_PI);
            end else begin
                x_reg <= -y_ext;
                y_reg <= x_ext;
                z_reg <= WIDTH'(NEG_HALF_PI);
            end
        end else if (state == cordic_pkg::ITER) begin
            iter_cnt <= iter_cnt + CW'(1);
            if (!y_reg[XW-1]) begin
                x_reg <= x_reg + y_shift;
                y_reg <= y_reg - x_shift;
                z_reg <= z_reg + atan_step;
            end else begin
                x_reg <= x_reg - y_shift;
                y_reg <= y_reg + x_shift;
                z_reg <= z_reg - atan_step;
            end
        end else if (state == SCALE) begin
            mag_out   <= zero_flag ? '0 : scaled_mag;
            angle_out <= zero_flag ? '0 : z_reg;
        end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// Self-checking bench for cordic_vec. Expected results come from real-valued
// sqrt/atan2 of the accepted inputs; one negedge monitor compares every cycle
// that out_valid is high, including hold stability and accept-to-valid latency.
module tb_cordic_vec;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mag_out;
    logic [15:0] angle_out;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int accept_count = 0;
    bit random_ready = 1'b0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          accept_edge;
        bit          seen;
        logic [15:0] first_mag;
        logic [15:0] first_ang;
        int          ang_tol;
        bit          has_lit;
        int          lit_mag;
        int          lit_ang;
    } txn_t;

    txn_t pending[$];

    bit next_has_lit;
    int next_lit_mag;
    int next_lit_ang;
    int next_ang_tol;

    cordic_vec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Compare actual against required within a tolerance; angles compare mod 2*pi
    task automatic checkOutput(input string name, input int actual, input int expected,
                               input int tol, input bit circular);
        int diff;
        checks++;
        diff = actual - expected;
        if (circular) begin
            diff = diff & 32'h0000FFFF;
            if (diff >= 32768) diff -= 65536;
        end
        if (diff < -tol || diff > tol) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (tol %0d) at cycle %0d",
                     name, actual, expected, tol, cycle);
        end
    endtask

    // Ideal result: Euclidean magnitude (saturated) and atan2 in pi/32768 units
    function automatic void refModel(input logic [15:0] x, input logic [15:0] y,
                                     output int mag_exp, output int ang_exp);
        real xr, yr, m, a;
        if (x == 16'h0 && y == 16'h0) begin
            mag_exp = 0;
            ang_exp = 0;
            return;
        end
        xr = real'($signed(x));
        yr = real'($signed(y));
        m  = $sqrt(xr * xr + yr * yr);
        mag_exp = (m > 32767.0) ? 32767 : int'(m);
        a  = $atan2(yr, xr);
        ang_exp = int'(a * 32768.0 / PI) & 32'h0000FFFF;
    endfunction

    // Monitor: scoreboard push on accept, compare on every valid cycle
    always @(negedge clk) begin
        int   mag_exp;
        int   ang_exp;
        int   mag_tol;
        int   ang_tol;
        txn_t t;
        if (rst) begin
            pending.delete();
        end else begin
            if (out_valid) begin
                if (pending.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: got out_valid=1, required 0 at cycle %0d", cycle);
                end else begin
                    t = pending[0];
                    refModel(t.x, t.y, mag_exp, ang_exp);
                    mag_tol = (mag_exp == 0) ? 0 : 3;
                    ang_tol = (t.x == 16'h0 && t.y == 16'h0) ? 0 : t.ang_tol;
                    checkOutput("mag", mag_out, mag_exp, mag_tol, 1'b0);
                    checkOutput("angle", angle_out, ang_exp, ang_tol, 1'b1);
                    checkOutput("in_ready_done", in_ready, out_ready, 0, 1'b0);
                    if (!t.seen) begin
                        checkOutput("latency", cycle, t.accept_edge + 16, 0, 1'b0);
                        if (t.has_lit) begin
                            checkOutput("lit_mag", mag_out, t.lit_mag, 3, 1'b0);
                            checkOutput("lit_angle", angle_out, t.lit_ang, 4, 1'b1);
                        end
                        t.seen      = 1'b1;
                        t.first_mag = mag_out;
                        t.first_ang = angle_out;
                    end else begin
                        checkOutput("hold_mag", mag_out, t.first_mag, 0, 1'b0);
                        checkOutput("hold_angle", angle_out, t.first_ang, 0, 1'b0);
                    end
                    pending[0] = t;
                    if (out_ready) void'(pending.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                t.x           = x_in;
                t.y           = y_in;
                t.accept_edge = cycle + 1;
                t.seen        = 1'b0;
                t.first_mag   = '0;
                t.first_ang   = '0;
                t.ang_tol     = next_ang_tol;
                t.has_lit     = next_has_lit;
                t.lit_mag     = next_lit_mag;
                t.lit_ang     = next_lit_ang;
                pending.push_back(t);
                accept_count++;
            end
        end
    end

    // Advance to just after the next rising edge, optionally jittering out_ready
    task automatic tick();
        @(posedge clk);
        #1;
        if (random_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present one input and hold it until the DUT accepts it
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input bit has_lit, input int lit_mag,
                                 input int lit_ang, input int ang_tol);
        int start_count;
        int n;
        next_has_lit = has_lit;
        next_lit_mag = lit_mag;
        next_lit_ang = lit_ang;
        next_ang_tol = ang_tol;
        start_count  = accept_count;
        x_in     = x;
        y_in     = y;
        in_valid = 1'b1;
        n = 0;
        while (accept_count == start_count && n < 200) begin
            tick();
            n++;
        end
        checkOutput("accept_timeout", int'(accept_count != start_count), 1, 0, 1'b0);
        in_valid = 1'b0;
    endtask

    // Wait until every accepted operation has been delivered
    task automatic waitDrain();
        int n;
        n = 0;
        while ((pending.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        checkOutput("drain_timeout", int'(pending.size() == 0 && !out_valid), 1, 0, 1'b0);
    endtask

    initial begin
        int m;
        int a;
        int n;
        int xr;
        int yr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;

        // Pin the reference model with hand-computed values
        refModel(16'h1000, 16'h1000, m, a);
        checkOutput("model_q1_mag", m, 32'h16A1, 0, 1'b0);
        checkOutput("model_q1_angle", a, 32'h2000, 0, 1'b1);
        refModel(16'hF000, 16'h1000, m, a);
        checkOutput("model_q2_angle", a, 32'h6000, 0, 1'b1);
        refModel(16'hF000, 16'hF000, m, a);
        checkOutput("model_q3_angle", a, 32'hA000, 0, 1'b1);

        // Reset state
        tick();
        tick();
        checkOutput("reset_out_valid", out_valid, 0, 0, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1, 0, 1'b0);
        checkOutput("reset_mag", mag_out, 0, 0, 1'b0);
        checkOutput("reset_angle", angle_out, 0, 0, 1'b0);
        rst = 1'b0;
        tick();

        // Directed cases with literal expectations
        applyStimulus(16'h1000, 16'h0000, 1'b1, 32'h1000, 32'h0000, 4);
        waitDrain();
        applyStimulus(16'h1000, 16'h1000, 1'b1, 32'h16A1, 32'h2000, 4);
        waitDrain();
        applyStimulus(16'hF000, 16'h1000, 1'b1, 32'h16A1, 32'h6000, 4);
        waitDrain();
        applyStimulus(16'hF000, 16'hF000, 1'b1, 32'h16A1, 32'hA000, 4);
        waitDrain();
        applyStimulus(16'hF000, 16'h0000, 1'b1, 32'h1000, 32'h8000, 4);
        waitDrain();
        applyStimulus(16'h0000, 16'h0000, 1'b1, 32'h0000, 32'h0000, 0);
        waitDrain();
        applyStimulus(16'h7FFF, 16'h7FFF, 1'b1, 32'h7FFF, 32'h2000, 4);
        waitDrain();

        // Backpressure: hold the result, then consume and accept on one edge
        out_ready = 1'b0;
        applyStimulus(16'h1000, 16'h0000, 1'b1, 32'h1000, 32'h0000, 4);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput("bp_valid_seen", out_valid, 1, 0, 1'b0);
        repeat (10) tick();
        checkOutput("bp_in_ready", in_ready, 0, 0, 1'b0);
        checkOutput("bp_still_valid", out_valid, 1, 0, 1'b0);
        out_ready = 1'b1;
        applyStimulus(16'h1000, 16'h1000, 1'b1, 32'h16A1, 32'h2000, 4);
        waitDrain();

        // Reset while iterating at i = 7
        applyStimulus(16'h1000, 16'h1000, 1'b1, 32'h16A1, 32'h2000, 4);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 0, 0, 1'b0);
        checkOutput("midrst_mag", mag_out, 0, 0, 1'b0);
        checkOutput("midrst_angle", angle_out, 0, 0, 1'b0);
        checkOutput("midrst_in_ready", in_ready, 1, 0, 1'b0);
        tick();
        applyStimulus(16'h1000, 16'h1000, 1'b1, 32'h16A1, 32'h2000, 4);
        waitDrain();

        // Random vectors inside the accurate range with random consumer stalls.
        // The arctangent table entries are truncated rather than rounded, so
        // their error accumulates over arbitrary rotation sequences; random
        // angles get a wider window than the directed ones.
        random_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            n = 0;
            do begin
                xr = int'($urandom_range(0, 32'h4000)) - 32'h2000;
                yr = int'($urandom_range(0, 32'h4000)) - 32'h2000;
                n++;
            end while ((xr * xr + yr * yr) < (6144 * 6144) && n < 100);
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(16'(xr), 16'(yr), 1'b0, 0, 0, 10);
        end
        waitDrain();
        random_ready = 1'b0;
        out_ready    = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cordic_vec.md
Name: cordic_vec

Overview:
- Iterative vectoring-mode CORDIC. Takes a column pair (x, y) and returns magnitude sqrt(x^2+y^2) and angle atan2(y, x).
- Sits directly upstream of cordic_rot in the QR decomposition datapath. The angle it produces drives the Givens rotation of the remaining row elements.
- Angle and data formats match cordic_rot, so angle_out connects to it unmodified.

Parameters:
- WIDTH, 16, data/angle word width.
- FRAC, 12, fractional bits of data (Q4.12).
- ITER, 15, CORDIC micro-rotations.
- GUARD, 2, extra MSBs in internal x/y registers.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x_in/y_in valid.
- in_ready  out  1  block can accept an input.
- x_in  in  WIDTH  signed Q4.12 x component.
- y_in  in  WIDTH  signed Q4.12 y component.
- out_valid  out  1  mag_out/angle_out valid.
- out_ready  in  1  consumer accepts the result.
- mag_out  out  WIDTH  signed Q4.12 magnitude, always >= 0.
- angle_out  out  WIDTH  signed angle; 0x4000 = +pi/2, 0x8000 = -pi, LSB = pi/32768.

Behaviour:
- Reset, at any clk edge with rst=1: state IDLE, in_ready=1, out_valid=0, mag_out=0, angle_out=0. Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1.
  - ITER: 15 cycles, counter i = 0..14.
  - SCALE: 1 cycle.
  - DONE: out_valid=1.
- Accept occurs when in_valid & in_ready at an edge, in IDLE or in DONE with out_ready=1. On accept, load pre-rotated values, clear i, go to ITER.
- Pre-rotation (quadrant fold), with x, y sign-extended to WIDTH+GUARD:
  - x >= 0: x0=x, y0=y, z0=0.
  - x < 0 and y >= 0: x0=y, y0=-x, z0=0x4000.
  - x < 0 and y < 0: x0=-y, y0=x, z0=0xC000.
- Zero input: if x=y=0 at accept, set a zero flag. The result is forced to mag 0, angle 0.
- ITER step i:
  - y_i >= 0: x += y>>>i, y -= x>>>i, z += atan[i].
  - y_i < 0: x -= y>>>i, y += x>>>i, z -= atan[i].
  - Use arithmetic shifts. Both updates use old x/y values.
  - z arithmetic is WIDTH-bit wrap-around modulo 2*pi, intended.
  - Leave ITER after i=14.
- atan table: atan(2^-i) in angle LSBs. Values 0x2000, 0x12E4, 0x09FB, 0x0511, 0x028B, 0x0145, 0x00A2, 0x0051, 0x0028, 0x0014, 0x000A, 0x0005, 0x0002, 0x0001, 0x0000.
- SCALE:
  - mag = (x * K) >>> FRAC, with K = 0x09B7 (0.60725).
  - Full-precision product of (WIDTH+GUARD) x WIDTH bits.
  - Saturate to 0x7FFF if the result exceeds WIDTH; clamp negative residue to 0.
  - angle_out = z.
  - Register both outputs, assert out_valid, go to DONE.
- Latency: out_valid rises 16 clk edges after the accepting edge.
- DONE:
  - Outputs and out_valid are held stable while out_ready=0.
  - out_ready=1 and in_valid=0: drop out_valid, go to IDLE.
  - out_ready=1 and in_valid=1: result consumed and new input accepted on the same edge, go to ITER. out_valid falls that edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Input range: |x_in|, |y_in| <= 0x2000 (2.0) is the guaranteed-accurate range. Larger inputs saturate mag_out; no wrap.
- Accuracy: mag within +-3 LSB and angle within +-4 LSB of ideal.
- x < 0, y = 0: angle_out is 0x8000 +-4 LSB, wrap-around accepted, -pi == +pi.
- Convention: rotating (x_in, y_in) with cordic_rot by -angle_out yields approximately (mag_out, 0).

Decomposition:
- Package cordic_pkg holds:
  - atan table constant array.
  - K factor 0x09B7.
  - Angle constants HALF_PI = 0x4000 and NEG_HALF_PI = 0xC000.
  - State enum {IDLE, ITER, SCALE, DONE}.
- cordic_rot is to be migrated to cordic_pkg so both blocks use the same constants.
- One sub-module: cordic_k_scale, combinational multiply-by-K, shift by FRAC, saturate/clamp. It is reusable by cordic_rot's output stage.

Test Plan:
- Axis input: x=0x1000, y=0x0000 -> mag 0x1000, angle 0x0000. out_valid exactly 16 edges after accept.
- First quadrant: x=0x1000, y=0x1000 -> mag 0x16A1, angle 0x2000.
- Quadrant fold:
  - x=0xF000, y=0x1000 -> mag 0x16A1, angle 0x6000.
  - x=0xF000, y=0xF000 -> angle 0xA000.
  - x=0xF000, y=0 -> angle 0x8000 +-4.
- Zero input: x=0, y=0 -> mag 0x0000, angle 0x0000 exactly.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> accepted that edge. Next out_valid 16 edges later with correct result.
- Reset mid-operation: rst=1 for 1 cycle at i=7 -> next edge out_valid=0, mag_out=angle_out=0, in_ready=1. The following operation (0x1000, 0x1000) is correct.
